// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline chain: fetch counter, DEPTH control stages with stall,
// bubble and flush handling, and a saturating retire counter.
module ctrl_pipe_chain #(
    parameter int unsigned CTRL_W  = 24,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned PC_STEP = 4,
    parameter int unsigned RET_W   = 16
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    LE,
    input  logic                    S,
    input  logic [CTRL_W-1:0]       ctrl_in,
    input  logic                    br_taken,
    input  logic [PC_W-1:0]         br_target,
    input  logic [DEPTH-1:0]        flush_mask,
    output logic [PC_W-1:0]         front_q,
    output logic [DEPTH*CTRL_W-1:0] stage_ctrl,
    output logic [DEPTH-1:0]        stage_valid,
    output logic [RET_W-1:0]        retire_cnt,
    output logic                    stall_active
);

    localparam logic [RET_W-1:0] RET_MAX = {RET_W{1'b1}};

    logic [PC_W-1:0]              pc_q, pc_d;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [RET_W-1:0]             ret_q, ret_d;
    logic                         stall_q, stall_d;

    // Fetch counter: a redirect beats an advance and is taken even while stalled.
    always_comb begin
        pc_d = pc_q;
        if (br_taken) begin
            pc_d = br_target;
        end else if (LE) begin
            pc_d = PC_W'(pc_q + PC_W'(PC_STEP));
        end
    end

    // Stage next-state: stage 0 holds on stall, stage 1 takes a bubble, the rest always shift.
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;

        if (flush_mask[0]) begin
            ctrl_d[0]  = '0;
            valid_d[0] = 1'b0;
        end else if (LE) begin
            if (S) begin
                ctrl_d[0]  = '0;
                valid_d[0] = 1'b0;
            end else begin
                ctrl_d[0]  = ctrl_in;
                valid_d[0] = 1'b1;
            end
        end

        if (flush_mask[1] || !LE) begin
            ctrl_d[1]  = '0;
            valid_d[1] = 1'b0;
        end else begin
            ctrl_d[1]  = ctrl_q[0];
            valid_d[1] = valid_q[0];
        end

        for (int i = 2; i < int'(DEPTH); i++) begin
            if (flush_mask[i]) begin
                ctrl_d[i]  = '0;
                valid_d[i] = 1'b0;
            end else begin
                ctrl_d[i]  = ctrl_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    // Retire counts the word leaving the last stage, even if that stage is flushed now.
    always_comb begin
        ret_d = ret_q;
        if (valid_q[DEPTH-1] && (ret_q != RET_MAX)) begin
            ret_d = RET_W'(ret_q + RET_W'(1));
        end
        stall_d = ~LE;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q    <= '0;
            ctrl_q  <= '0;
            valid_q <= '0;
            ret_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            ret_q   <= ret_d;
            stall_q <= stall_d;
        end
    end

    assign front_q      = pc_q;
    assign stage_ctrl   = ctrl_q;
    assign stage_valid  = valid_q;
    assign retire_cnt   = ret_q;
    assign stall_active = stall_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Randomized bench for ctrl_pipe_chain against a per-edge behavioural model;
// a second instance with a 2-bit retire counter exercises saturation.
module tb_ctrl_pipe_chain;

    localparam int unsigned CTRL_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PC_W   = 8;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              LE = 1'b0;
    logic              S = 1'b0;
    logic [CTRL_W-1:0] ctrl_in = '0;
    logic              br_taken = 1'b0;
    logic [PC_W-1:0]   br_target = '0;
    logic [DEPTH-1:0]  flush_mask = '0;

    logic [PC_W-1:0]         front_q, sat_front;
    logic [DEPTH*CTRL_W-1:0] stage_ctrl, sat_ctrl;
    logic [DEPTH-1:0]        stage_valid, sat_valid;
    logic [15:0]             retire_cnt;
    logic [1:0]              sat_retire;
    logic                    stall_active, sat_stall;

    ctrl_pipe_chain #(.CTRL_W(CTRL_W), .DEPTH(DEPTH), .PC_W(PC_W), .PC_STEP(4), .RET_W(16)) u_dut (
        .Clk(Clk), .Rst(Rst), .LE(LE), .S(S), .ctrl_in(ctrl_in), .br_taken(br_taken),
        .br_target(br_target), .flush_mask(flush_mask), .front_q(front_q), .stage_ctrl(stage_ctrl),
        .stage_valid(stage_valid), .retire_cnt(retire_cnt), .stall_active(stall_active)
    );

    ctrl_pipe_chain #(.CTRL_W(CTRL_W), .DEPTH(DEPTH), .PC_W(PC_W), .PC_STEP(4), .RET_W(2)) u_sat (
        .Clk(Clk), .Rst(Rst), .LE(LE), .S(S), .ctrl_in(ctrl_in), .br_taken(br_taken),
        .br_target(br_target), .flush_mask(flush_mask), .front_q(sat_front), .stage_ctrl(sat_ctrl),
        .stage_valid(sat_valid), .retire_cnt(sat_retire), .stall_active(sat_stall)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what each stage holds, as plain values.
    int unsigned m_front;
    int unsigned m_word [DEPTH];
    bit          m_live [DEPTH];
    int unsigned m_ret;
    int unsigned m_sat;
    bit          m_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply the stage rules for one edge using the inputs currently driven.
    task automatic model_edge();
        int unsigned w_old [DEPTH];
        bit          l_old [DEPTH];
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_old[i] = m_word[i];
            l_old[i] = m_live[i];
        end
        if (Rst) begin
            m_front = 0;
            m_ret   = 0;
            m_sat   = 0;
            m_stall = 0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                m_word[i] = 0;
                m_live[i] = 0;
            end
            return;
        end
        if (l_old[DEPTH-1]) begin
            if (m_ret < 65535) m_ret++;
            if (m_sat < 3) m_sat++;
        end
        if (flush_mask[0]) begin
            m_word[0] = 0; m_live[0] = 0;
        end else if (LE) begin
            m_word[0] = S ? 0 : int'(ctrl_in);
            m_live[0] = !S;
        end
        if (flush_mask[1] || !LE) begin
            m_word[1] = 0; m_live[1] = 0;
        end else begin
            m_word[1] = w_old[0]; m_live[1] = l_old[0];
        end
        for (int i = 2; i < int'(DEPTH); i++) begin
            m_word[i] = flush_mask[i] ? 0 : w_old[i-1];
            m_live[i] = flush_mask[i] ? 0 : l_old[i-1];
        end
        if (br_taken) m_front = int'(br_target);
        else if (LE) m_front = (m_front + 4) % 256;
        m_stall = !LE;
    endtask

    task automatic check_all();
        logic [DEPTH*CTRL_W-1:0] e_ctrl;
        logic [DEPTH-1:0]        e_valid;
        for (int i = 0; i < int'(DEPTH); i++) begin
            e_ctrl[i*CTRL_W +: CTRL_W] = CTRL_W'(m_word[i]);
            e_valid[i] = m_live[i];
        end
        chk("front_q", 64'(front_q), 64'(m_front));
        chk("stage_ctrl", 64'(stage_ctrl), 64'(e_ctrl));
        chk("stage_valid", 64'(stage_valid), 64'(e_valid));
        chk("retire_cnt", 64'(retire_cnt), 64'(m_ret));
        chk("retire_sat", 64'(sat_retire), 64'(m_sat));
        chk("stall_active", 64'(stall_active), 64'(m_stall));
    endtask

    task automatic step(input bit rst, input bit le, input bit s, input logic [7:0] ci,
                        input bit br, input logic [7:0] tgt, input logic [3:0] fm);
        Rst = rst; LE = le; S = s; ctrl_in = ci;
        br_taken = br; br_target = tgt; flush_mask = fm;
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        #2;
        // Reset and the first stream of words.
        step(1, 1, 0, 8'h99, 1, 8'h55, 4'h0);
        chk("rst_front", 64'(front_q), 64'h0);
        chk("rst_valid", 64'(stage_valid), 64'h0);
        step(0, 1, 0, 8'h11, 0, 8'h00, 4'h0);
        chk("first_front", 64'(front_q), 64'h4);
        step(0, 1, 0, 8'h22, 0, 8'h00, 4'h0);
        // Two-cycle stall with 0x22 in stage 0.
        step(0, 0, 0, 8'h33, 0, 8'h00, 4'h0);
        chk("stall_s0", 64'(stage_ctrl[7:0]), 64'h22);
        chk("stall_flag", 64'(stall_active), 64'h1);
        step(0, 0, 1, 8'h33, 0, 8'h00, 4'h0);
        chk("stall_front", 64'(front_q), 64'h8);
        chk("s3_after4", 64'(stage_ctrl[31:24]), 64'h11);
        chk("stall_s1_bubble", 64'(stage_valid[1]), 64'h0);
        step(0, 1, 0, 8'h33, 0, 8'h00, 4'h0);
        chk("first_retire", 64'(retire_cnt), 64'h1);
        chk("resume_s1", 64'(stage_ctrl[15:8]), 64'h22);
        // Redirect combined with a front flush.
        step(0, 1, 0, 8'h44, 1, 8'h40, 4'b0011);
        chk("br_front", 64'(front_q), 64'h40);
        chk("br_valid", 64'(stage_valid), 64'b0100);
        // Three NOP selects.
        for (int k = 0; k < 3; k++) step(0, 1, 1, 8'hA0 + 8'(k), 0, 8'h00, 4'h0);
        chk("nop_s0", 64'(stage_valid[0]), 64'h0);
        for (int k = 0; k < 6; k++) step(0, 1, 0, 8'h50 + 8'(k), 0, 8'h00, 4'h0);
        // Fetch counter wrap.
        step(0, 1, 0, 8'h61, 1, 8'hFC, 4'h0);
        step(0, 1, 0, 8'h62, 0, 8'h00, 4'h0);
        chk("wrap_front", 64'(front_q), 64'h0);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 8'h70 + 8'(k), 0, 8'h00, 4'h0);
        chk("full_valid", 64'(stage_valid), 64'hF);
        chk("sat_retire", 64'(sat_retire), 64'h3);
        // Reset mid-operation with all stages live.
        step(1, 1, 0, 8'h7F, 1, 8'h80, 4'h0);
        chk("midrst_valid", 64'(stage_valid), 64'h0);
        chk("midrst_ret", 64'(retire_cnt), 64'h0);
        chk("midrst_front", 64'(front_q), 64'h0);
        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(99) < 2), ($urandom_range(99) < 80), ($urandom_range(99) < 20),
                 8'($urandom), ($urandom_range(99) < 10), 8'($urandom),
                 ($urandom_range(99) < 15) ? 4'($urandom) : 4'h0);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
